gen_gamma_decoder: RTL and testbench

//   Receive end of the gamma coding path: accepts a noise key (nk) and a mixed word (md = id + nk)

---
 rtl/gen_gamma_pkg.sv | 20 ++
 rtl/gamma_subtractor.sv | 23 ++
 rtl/gen_gamma_reg.sv | 26 ++
 rtl/gen_gamma_decoder.sv | 162 ++++++++++++++++
 tb/tb_gen_gamma_decoder.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gen_gamma_pkg.sv
// Shared definitions for the gamma decode path: default word width,
// decoder FSM states and the consistency check on a raw difference.
package gen_gamma_pkg;

    localparam int SIZE_DEF = 8;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CALC    = 2'd1,
        HOLD    = 2'd2
    } dec_state_t;

    // diff_hi holds the two top bits of the (SIZE+2)-bit difference md - nk:
    // bit 1 is the borrow (md < nk), bit 0 is set when the result needs
    // more than SIZE bits. Either one makes the pair inconsistent.
    function automatic logic gamma_check(input logic [1:0] diff_hi);
        return diff_hi[1] | diff_hi[0];
    endfunction

endpackage

// File: rtl/gamma_subtractor.sv
// Combinational inverse of the coder adder: md - nk evaluated exactly over
// SIZE+2 bits, split into the truncated word and its two status bits.
module gamma_subtractor #(
    parameter int SIZE = 8
) (
    input  logic [SIZE:0]   md_i,
    input  logic [SIZE-1:0] nk_i,
    output logic [SIZE-1:0] diff_o,
    output logic            borrow_o,
    output logic            overflow_o
);

    logic [SIZE+1:0] full_diff;

    // Zero-extend both operands so the borrow lands in the top bit.
    always_comb begin
        full_diff  = {1'b0, md_i} - {2'b00, nk_i};
        diff_o     = full_diff[SIZE-1:0];
        borrow_o   = full_diff[SIZE+1];
        overflow_o = full_diff[SIZE];
    end

endmodule

// File: rtl/gen_gamma_reg.sv
// Generic load-enable storage register with asynchronous clear.
module gen_gamma_reg #(
    parameter int          W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Load d_i whenever set_i is high, otherwise keep the stored value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else if (set_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/gen_gamma_decoder.sv
// Receive side of the gamma path: collects a noise key and a mixed word on
// independent valid/ready channels, subtracts them, and presents the
// recovered word on a held valid/ready output with an error flag and a
// saturating count of accepted inconsistent pairs.
module gen_gamma_decoder
    import gen_gamma_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nk_valid,
    output logic             nk_ready,
    input  logic [SIZE-1:0]  nk,
    input  logic             md_valid,
    output logic             md_ready,
    input  logic [SIZE:0]    md,
    output logic             od_valid,
    input  logic             od_ready,
    output logic [SIZE-1:0]  od,
    output logic             od_err,
    output logic [CNT_W-1:0] err_cnt
);

    dec_state_t       state_q, state_d;
    logic             have_nk_q, have_nk_d;
    logic             have_md_q, have_md_d;
    logic             od_valid_q, od_valid_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [SIZE-1:0]  nk_q;
    logic [SIZE:0]    md_q;
    logic [SIZE-1:0]  od_q;
    logic             od_err_q;

    logic [SIZE-1:0]  sub_diff;
    logic             sub_borrow;
    logic             sub_overflow;
    logic             calc_err;

    logic             nk_fire;
    logic             md_fire;
    logic             od_fire;
    logic             calc_en;

    // Readies come only from registered state so they never depend on the
    // same-cycle valid; a captured operand blocks its channel until the
    // result has been handed off.
    assign nk_ready = (state_q == COLLECT) && !have_nk_q;
    assign md_ready = (state_q == COLLECT) && !have_md_q;
    assign nk_fire  = nk_valid && nk_ready;
    assign md_fire  = md_valid && md_ready;
    assign od_fire  = od_valid_q && od_ready;
    assign calc_en  = (state_q == CALC);

    gen_gamma_reg #(.W(SIZE)) u_nk_reg (
        .clk   (clk),
        .rst   (rst),
        .set_i (nk_fire),
        .d_i   (nk),
        .q_o   (nk_q)
    );

    gen_gamma_reg #(.W(SIZE + 1)) u_md_reg (
        .clk   (clk),
        .rst   (rst),
        .set_i (md_fire),
        .d_i   (md),
        .q_o   (md_q)
    );

    gamma_subtractor #(.SIZE(SIZE)) u_sub (
        .md_i       (md_q),
        .nk_i       (nk_q),
        .diff_o     (sub_diff),
        .borrow_o   (sub_borrow),
        .overflow_o (sub_overflow)
    );

    assign calc_err = gamma_check({sub_borrow, sub_overflow});

    // The result registers load only in CALC, so od keeps its last value
    // through HOLD and after the handshake.
    gen_gamma_reg #(.W(SIZE)) u_od_reg (
        .clk   (clk),
        .rst   (rst),
        .set_i (calc_en),
        .d_i   (sub_diff),
        .q_o   (od_q)
    );

    gen_gamma_reg #(.W(1)) u_od_err_reg (
        .clk   (clk),
        .rst   (rst),
        .set_i (calc_en),
        .d_i   (calc_err),
        .q_o   (od_err_q)
    );

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            have_nk_q  <= 1'b0;
            have_md_q  <= 1'b0;
            od_valid_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            have_nk_q  <= have_nk_d;
            have_md_q  <= have_md_d;
            od_valid_q <= od_valid_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Next-state logic: gather both operands, spend one cycle computing,
    // then hold the result until the consumer takes it.
    always_comb begin
        state_d    = state_q;
        have_nk_d  = have_nk_q;
        have_md_d  = have_md_q;
        od_valid_d = od_valid_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            COLLECT: begin
                have_nk_d = have_nk_q | nk_fire;
                have_md_d = have_md_q | md_fire;
                // Both flags registered: the pair is complete, compute next.
                if (have_nk_q && have_md_q) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                od_valid_d = 1'b1;
                have_nk_d  = 1'b0;
                have_md_d  = 1'b0;
                state_d    = HOLD;
            end
            HOLD: begin
                if (od_fire) begin
                    od_valid_d = 1'b0;
                    if (od_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    assign od_valid = od_valid_q;
    assign od       = od_q;
    assign od_err   = od_err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gen_gamma_decoder.sv
// Bench for gen_gamma_decoder: directed scenarios with literal results plus
// a long randomized run, all checked cycle by cycle against a transaction
// model (operand lists, pairing by order, arithmetic on integers).
module tb_gen_gamma_decoder;

    logic       clk;
    logic       rst;
    logic       nk_valid;
    logic       nk_ready;
    logic [7:0] nk;
    logic       md_valid;
    logic       md_ready;
    logic [8:0] md;
    logic       od_valid;
    logic       od_ready;
    logic [7:0] od;
    logic       od_err;
    logic [7:0] err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    gen_gamma_decoder #(.SIZE(8), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .nk_valid (nk_valid),
        .nk_ready (nk_ready),
        .nk       (nk),
        .md_valid (md_valid),
        .md_ready (md_ready),
        .md       (md),
        .od_valid (od_valid),
        .od_ready (od_ready),
        .od       (od),
        .od_err   (od_err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    // The k-th accepted key pairs with the k-th accepted mixed word. A
    // channel is open exactly when it has no operand waiting for a result
    // hand-off; a result is presented three sampling cycles after the
    // cycle in which its pair became complete, until it is accepted.
    logic [7:0] m_nk     [0:4095];
    logic [8:0] m_md     [0:4095];
    int         m_nk_cyc [0:4095];
    int         m_md_cyc [0:4095];
    int         n_nk, n_md, n_acc, cyc, m_err_cnt;
    int         done_cyc, diff;
    logic       e_nk_rdy, e_md_rdy, e_valid, e_err;

    initial begin
        n_nk = 0; n_md = 0; n_acc = 0; cyc = 0; m_err_cnt = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            n_nk = 0; n_md = 0; n_acc = 0; m_err_cnt = 0;
            check("rst_od_valid", od_valid, 0);
            check("rst_od", od, 0);
            check("rst_od_err", od_err, 0);
            check("rst_err_cnt", err_cnt, 0);
        end else begin
            cyc++;
            e_nk_rdy = (n_nk == n_acc);
            e_md_rdy = (n_md == n_acc);
            e_valid  = 1'b0;
            e_err    = 1'b0;
            if (n_nk > n_acc && n_md > n_acc) begin
                done_cyc = (m_nk_cyc[n_acc] > m_md_cyc[n_acc]) ? m_nk_cyc[n_acc] : m_md_cyc[n_acc];
                e_valid  = (cyc >= done_cyc + 3);
            end
            check("nk_ready", nk_ready, e_nk_rdy);
            check("md_ready", md_ready, e_md_rdy);
            check("od_valid", od_valid, e_valid);
            if (e_valid) begin
                diff  = int'(m_md[n_acc]) - int'(m_nk[n_acc]);
                e_err = (diff < 0) || (diff >= 256);
                check("od", od, diff & 255);
                check("od_err", od_err, e_err);
            end
            check("err_cnt", err_cnt, m_err_cnt);
            // Transfers that happen at the coming rising edge.
            if (nk_valid && e_nk_rdy) begin
                m_nk[n_nk] = nk; m_nk_cyc[n_nk] = cyc; n_nk++;
            end
            if (md_valid && e_md_rdy) begin
                m_md[n_md] = md; m_md_cyc[n_md] = cyc; n_md++;
            end
            if (e_valid && od_ready) begin
                if (e_err && m_err_cnt < 255) m_err_cnt++;
                n_acc++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!od_valid && n < 12) begin
            tick();
            n++;
        end
        check(name, od_valid, 1);
    endtask

    task automatic accept();
        od_ready = 1'b1;
        tick();
        od_ready = 1'b0;
    endtask

    // Offer key and mixed word together, then check and take the result.
    task automatic pair(input logic [7:0] k, input logic [8:0] m,
                        input logic [7:0] e_od, input logic e_e, input string name);
        nk_valid = 1'b1; nk = k;
        md_valid = 1'b1; md = m;
        tick();
        nk_valid = 1'b0;
        md_valid = 1'b0;
        wait_valid({name, "_valid"});
        check({name, "_od"}, od, e_od);
        check({name, "_err"}, od_err, e_e);
        accept();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        nk_valid = 1'b0; nk = '0;
        md_valid = 1'b0; md = '0;
        od_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("t0_nk_ready", nk_ready, 1);
        check("t0_md_ready", md_ready, 1);

        // 1: key then mixed word on separate cycles, exact latency
        nk_valid = 1'b1; nk = 8'h5A;
        tick();
        nk_valid = 1'b0;
        md_valid = 1'b1; md = 9'h0F3;
        tick();
        md_valid = 1'b0;
        check("t1_lat0", od_valid, 0);
        tick();
        check("t1_lat1", od_valid, 0);
        tick();
        check("t1_lat2", od_valid, 1);
        check("t1_od", od, 8'h99);
        check("t1_err", od_err, 0);
        accept();
        check("t1_taken", od_valid, 0);

        // 2: same-cycle capture, extremes
        pair(8'hFF, 9'h1FE, 8'hFF, 1'b0, "t2a");
        pair(8'h00, 9'h000, 8'h00, 1'b0, "t2b");

        // 3: inconsistent pairs and the error counter
        pair(8'h10, 9'h008, 8'hF8, 1'b1, "t3a");
        check("t3a_cnt", err_cnt, 1);
        pair(8'h00, 9'h100, 8'h00, 1'b1, "t3b");
        check("t3b_cnt", err_cnt, 2);

        // 4: backpressure with the next pair already offered
        nk_valid = 1'b1; nk = 8'h20;
        md_valid = 1'b1; md = 9'h0A0;
        tick();
        nk = 8'h01; md = 9'h003;
        wait_valid("t4_valid");
        for (int i = 0; i < 5; i++) begin
            check("t4_nk_ready", nk_ready, 0);
            check("t4_md_ready", md_ready, 0);
            check("t4_od", od, 8'h80);
            check("t4_err", od_err, 0);
            tick();
        end
        accept();
        check("t4_reopen", nk_ready, 1);
        tick();
        nk_valid = 1'b0;
        md_valid = 1'b0;
        wait_valid("t4b_valid");
        check("t4b_od", od, 8'h02);
        accept();

        // 5: mixed word first, key three cycles later
        md_valid = 1'b1; md = 9'h100;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t5_md_ready", md_ready, 0);
            tick();
        end
        nk_valid = 1'b1; nk = 8'h80;
        tick();
        nk_valid = 1'b0;
        md_valid = 1'b0;
        check("t5_md_ready_calc", md_ready, 0);
        wait_valid("t5_valid");
        check("t5_od", od, 8'h80);
        check("t5_err", od_err, 0);
        accept();
        check("t5_cnt", err_cnt, 2);

        // 6: reset with a partial pair, then with a pending erroneous output
        nk_valid = 1'b1; nk = 8'h11;
        tick();
        nk_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("t6_od", od, 0);
        check("t6_cnt", err_cnt, 0);
        rst = 1'b0;
        tick();
        check("t6_nk_ready", nk_ready, 1);
        check("t6_md_ready", md_ready, 1);
        for (int i = 0; i < 3; i++) pair(8'h10, 9'h008, 8'hF8, 1'b1, "t6e");
        check("t6_cnt3", err_cnt, 3);
        nk_valid = 1'b1; nk = 8'hFF;
        md_valid = 1'b1; md = 9'h000;
        tick();
        nk_valid = 1'b0;
        md_valid = 1'b0;
        wait_valid("t6_pending");
        rst = 1'b1;
        tick();
        check("t6r_valid", od_valid, 0);
        check("t6r_cnt", err_cnt, 0);
        check("t6r_err", od_err, 0);
        rst = 1'b0;
        tick();
        md_valid = 1'b1; md = 9'h055;
        tick();
        md_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("t6_md_alone", od_valid, 0);
            tick();
        end

        // Randomized traffic; long enough to drive err_cnt into saturation.
        for (int i = 0; i < 8000; i++) begin
            nk_valid = ($urandom_range(0, 3) != 0);
            nk       = 8'($urandom);
            md_valid = ($urandom_range(0, 3) != 0);
            md       = 9'($urandom);
            od_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        nk_valid = 1'b0;
        md_valid = 1'b0;
        od_ready = 1'b1;
        repeat (10) tick();
        check("final_cnt_saturated", err_cnt, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
